tl_ul_a_arbiter: RTL and testbench
==================================

Name: tl_ul_a_arbiter

Overview:
- 2-to-1 TileLink-UL arbiter that shares one downstream TL-UL slave port between two upstream masters.
- Round-robin arbitration on the A channel, with a grant lock for multi-beat Put bursts and for stalled beats.
- Routes D-channel responses back to the originating master using a source-ID tag bit.
- Caps outstanding transactions per master so the downstream TL-UL protocol monitor never sees source reuse.

Parameters:
SRC_W, 4, upstream source-ID width; downstream source width is SRC_W+1.
SIZE_W, 3, a_size/d_size width (log2 bytes).
MAX_OUT, 4, max outstanding transactions per master (1..15).

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-high reset
inN_a_valid  input  1  master N request valid (N = 0,1; same for every inN_* line below)
inN_a_ready  output  1  master N request accepted
inN_a_opcode  input  3  TL-UL A opcode (0 PutFull, 1 PutPartial, 4 Get)
inN_a_size  input  SIZE_W  log2 transfer bytes
inN_a_source  input  SRC_W  master N source ID
inN_a_address  input  32  byte address
inN_a_mask  input  4  byte lanes
inN_a_data  input  32  write data
out_a_valid  output  1  downstream request valid
out_a_ready  input  1  downstream accept
out_a_opcode/size/address/mask/data  output  3/SIZE_W/32/4/32  muxed A fields
out_a_source  output  SRC_W+1  {grant index, inN_a_source}
out_d_valid  input  1  response valid
out_d_ready  output  1  response accepted
out_d_opcode/size/source/data/denied/corrupt  input  3/SIZE_W/SRC_W+1/32/1/1  response fields
inN_d_valid  output  1  response to master N
inN_d_ready  input  1  master N response accept
inN_d_opcode/size/source/data/denied/corrupt  output  3/SIZE_W/SRC_W/32/1/1  fields; source = out_d_source[SRC_W-1:0]

Behaviour:
- Reset: lock=0, lock_idx=0, rr_ptr=0 (master 0 wins first tie), a_beats=0, d_beats=0, outN_cnt=0. With no inN_a_valid, all outputs are 0 except out_d_ready, which follows the D routing rule.
- Eligibility: eligN = inN_a_valid && (outN_cnt < MAX_OUT). The count check applies only on a first beat.
- Selection when !lock:
  - Only one master eligible: grant it.
  - Both eligible: grant rr_ptr.
  - Zero-cycle combinational grant: out_a_valid = elig[grant].
- Selection when lock: grant = lock_idx; out_a_valid = in[lock_idx]_a_valid; the count check is bypassed.
- Data path: out_a_* = in[grant]_a_*; in[grant]_a_ready = out_a_ready && out_a_valid; the other master's ready = 0.
- A beat count: beats = (opcode in {0,1} && size > 2) ? 2^(size-2) : 1.
- A-channel state:
  - IDLE→LOCKED when out_a_valid && !out_a_ready: lock=1, lock_idx=grant. This keeps valid/payload stable per TL rules.
  - First beat fires with beats>1: lock=1, a_beats = beats-1.
  - In LOCKED, each fire decrements a_beats.
  - Fire with a_beats==1 (burst last), or a single-beat fire: lock=0, rr_ptr = ~grant.
  - Last-beat release and the opposite master's request in the same cycle: the opposite master wins next cycle.
- Outstanding count: outN_cnt +1 on the first A beat fire of master N. outN_cnt −1 on the last D beat for master N (index = out_d_source[SRC_W]). Inc and dec in the same cycle: net 0. Never exceeds MAX_OUT; never underflows, and a D response while the count is 0 is ignored for counting.
- D routing (pure combinational, no buffering):
  - idx = out_d_source[SRC_W]; in[idx]_d_valid = out_d_valid; out_d_ready = in[idx]_d_ready; the other inN_d_valid = 0.
  - D beats: AccessAckData (opcode 1) with d_size > 2 carries 2^(d_size-2) beats, otherwise 1. d_beats tracks the remaining count; the last beat is d_beats==1, or the first beat when beats==1.
- Reset mid-burst: all state clears next cycle; a partial burst is abandoned and no recovery is attempted.
- Size > 2 on Get: single A beat, multi-beat D.

Test Plan:
- Both masters issue Get size 2 every cycle, out_a_ready=1 → grants alternate 0,1,0,1; out_a_source MSB toggles; first grant is master 0 after reset.
- in0 PutFull size 4 (4 beats) while in1 Get is valid → 4 consecutive master-0 beats with in1_a_ready=0; master 1 granted on the 5th cycle.
- in1 valid, out_a_ready=0 for 3 cycles, in0 asserts during the stall → grant stays 1 and payload is stable; master 1 fires in cycle 4, master 0 in cycle 5.
- MAX_OUT=4, master 0 issues 5 Gets with no D → 4 fire; the 5th is held with in0_a_ready=0 while master 1 proceeds. One AccessAckData to source 5'b0_xxxx releases it the next cycle.
- AccessAckData size 3 with source MSB=1 → 2 beats on in1_d_*; in0_d_valid=0 throughout; out1_cnt decrements only after beat 2. Backpressure via in1_d_ready=0 stalls out_d_ready.
- Assert reset during the 2nd beat of a 4-beat Put → next cycle lock=0 and counts=0; the next simultaneous request is granted to master 0.

Source files
------------

// File: rtl/tl_ul_a_arbiter.sv
// tl_ul_a_arbiter
// ---------------------------------------------------------------------------
// Shares one downstream TL-UL slave port between two upstream masters.
//
// A channel: round-robin choice between eligible masters, with a zero-cycle
// combinational grant. The grant is held (locked) across the beats of a
// multi-beat Put burst and across any beat stalled by out_a_ready=0, so
// valid and payload stay stable until the beat is taken. The master index is
// prepended to the source ID so responses can be steered back.
//
// D channel: pure combinational routing on out_d_source[SRC_W]. No buffering.
//
// Per-master outstanding counters stop a master from issuing a new request
// once MAX_OUT of its transactions are in flight.
//
// Handshake rule: a beat transfers on a channel in a cycle where valid and
// ready are both high. Valid never depends on ready. Once valid is high the
// payload is held until the transfer.
//
// Ports
//   clock, reset              sole clock, synchronous active-high reset
//   inN_a_*                   upstream A channel of master N (N = 0,1)
//   out_a_*                   downstream A channel (source = {N, inN_a_source})
//   out_d_*                   downstream D channel
//   inN_d_*                   upstream D channel of master N
//   dbg_*                     arbiter state for observation
// ---------------------------------------------------------------------------
module tl_ul_a_arbiter #(
  parameter int SRC_W   = 4,
  parameter int SIZE_W  = 3,
  parameter int MAX_OUT = 4,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                in0_a_valid,
  output logic                in0_a_ready,
  input  logic [2:0]          in0_a_opcode,
  input  logic [SIZE_W-1:0]   in0_a_size,
  input  logic [SRC_W-1:0]    in0_a_source,
  input  logic [31:0]         in0_a_address,
  input  logic [3:0]          in0_a_mask,
  input  logic [31:0]         in0_a_data,

  input  logic                in1_a_valid,
  output logic                in1_a_ready,
  input  logic [2:0]          in1_a_opcode,
  input  logic [SIZE_W-1:0]   in1_a_size,
  input  logic [SRC_W-1:0]    in1_a_source,
  input  logic [31:0]         in1_a_address,
  input  logic [3:0]          in1_a_mask,
  input  logic [31:0]         in1_a_data,

  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_opcode,
  output logic [SIZE_W-1:0]   out_a_size,
  output logic [SRC_W:0]      out_a_source,
  output logic [31:0]         out_a_address,
  output logic [3:0]          out_a_mask,
  output logic [31:0]         out_a_data,

  input  logic                out_d_valid,
  output logic                out_d_ready,
  input  logic [2:0]          out_d_opcode,
  input  logic [SIZE_W-1:0]   out_d_size,
  input  logic [SRC_W:0]      out_d_source,
  input  logic [31:0]         out_d_data,
  input  logic                out_d_denied,
  input  logic                out_d_corrupt,

  output logic                in0_d_valid,
  input  logic                in0_d_ready,
  output logic [2:0]          in0_d_opcode,
  output logic [SIZE_W-1:0]   in0_d_size,
  output logic [SRC_W-1:0]    in0_d_source,
  output logic [31:0]         in0_d_data,
  output logic                in0_d_denied,
  output logic                in0_d_corrupt,

  output logic                in1_d_valid,
  input  logic                in1_d_ready,
  output logic [2:0]          in1_d_opcode,
  output logic [SIZE_W-1:0]   in1_d_size,
  output logic [SRC_W-1:0]    in1_d_source,
  output logic [31:0]         in1_d_data,
  output logic                in1_d_denied,
  output logic                in1_d_corrupt,

  output logic                dbg_lock,
  output logic                dbg_lock_idx,
  output logic                dbg_rr_ptr,
  output logic [CNT_W-1:0]    dbg_out0_cnt,
  output logic [CNT_W-1:0]    dbg_out1_cnt
);

  // Wide enough for the largest burst, 2^(2^SIZE_W - 3) beats.
  localparam int BEAT_W = (1 << SIZE_W) - 2;

  typedef enum logic {
    A_IDLE   = 1'b0,
    A_LOCKED = 1'b1
  } a_state_e;

  a_state_e              a_state;
  logic                  lock_idx;
  logic                  rr_ptr;
  // Remaining beats while locked; 0 while locked means the first beat of a
  // request was stalled and has not fired yet.
  logic [BEAT_W-1:0]     a_beats;
  logic [BEAT_W-1:0]     d_beats;
  logic [CNT_W-1:0]      out0_cnt;
  logic [CNT_W-1:0]      out1_cnt;

  function automatic logic [BEAT_W-1:0] a_beat_count(input logic [2:0]        opcode,
                                                     input logic [SIZE_W-1:0] size);
    if ((opcode == 3'd0 || opcode == 3'd1) && size > SIZE_W'(2))
      return BEAT_W'(1) << (size - SIZE_W'(2));
    else
      return BEAT_W'(1);
  endfunction

  function automatic logic [BEAT_W-1:0] d_beat_count(input logic [2:0]        opcode,
                                                     input logic [SIZE_W-1:0] size);
    if (opcode == 3'd1 && size > SIZE_W'(2))
      return BEAT_W'(1) << (size - SIZE_W'(2));
    else
      return BEAT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // A channel selection
  // ---------------------------------------------------------------------------
  logic              elig0;
  logic              elig1;
  logic              grant;
  logic              a_fire;
  logic              a_first;
  logic [BEAT_W-1:0] a_first_beats;
  logic [2:0]        sel_opcode;
  logic [SIZE_W-1:0] sel_size;
  logic [SRC_W-1:0]  sel_source;
  logic [31:0]       sel_address;
  logic [3:0]        sel_mask;
  logic [31:0]       sel_data;

  always_comb begin
    elig0       = in0_a_valid && (out0_cnt < CNT_W'(MAX_OUT));
    elig1       = in1_a_valid && (out1_cnt < CNT_W'(MAX_OUT));
    grant       = 1'b0;
    out_a_valid = 1'b0;
    if (a_state == A_LOCKED) begin
      // Count check bypassed: the request was already admitted.
      grant       = lock_idx;
      out_a_valid = lock_idx ? in1_a_valid : in0_a_valid;
    end else begin
      if (elig0 && elig1) grant = rr_ptr;
      else if (elig1)     grant = 1'b1;
      else                grant = 1'b0;
      out_a_valid = grant ? elig1 : elig0;
    end
  end

  always_comb begin
    sel_opcode  = grant ? in1_a_opcode  : in0_a_opcode;
    sel_size    = grant ? in1_a_size    : in0_a_size;
    sel_source  = grant ? in1_a_source  : in0_a_source;
    sel_address = grant ? in1_a_address : in0_a_address;
    sel_mask    = grant ? in1_a_mask    : in0_a_mask;
    sel_data    = grant ? in1_a_data    : in0_a_data;
  end

  // Payload is zeroed when nothing is offered so an idle port reads as 0.
  assign out_a_opcode  = out_a_valid ? sel_opcode  : '0;
  assign out_a_size    = out_a_valid ? sel_size    : '0;
  assign out_a_source  = out_a_valid ? {grant, sel_source} : '0;
  assign out_a_address = out_a_valid ? sel_address : '0;
  assign out_a_mask    = out_a_valid ? sel_mask    : '0;
  assign out_a_data    = out_a_valid ? sel_data    : '0;

  assign a_fire      = out_a_valid && out_a_ready;
  assign in0_a_ready = a_fire && !grant;
  assign in1_a_ready = a_fire &&  grant;

  // First beat of a request: any fire from IDLE, or the stalled first beat.
  assign a_first       = a_fire && (a_state == A_IDLE || a_beats == '0);
  assign a_first_beats = a_beat_count(sel_opcode, sel_size);

  // ---------------------------------------------------------------------------
  // D channel routing
  // ---------------------------------------------------------------------------
  logic              d_idx;
  logic              d_fire;
  logic              d_last;
  logic [BEAT_W-1:0] d_total;

  assign d_idx       = out_d_source[SRC_W];
  assign out_d_ready = d_idx ? in1_d_ready : in0_d_ready;
  assign d_fire      = out_d_valid && out_d_ready;
  assign d_total     = d_beat_count(out_d_opcode, out_d_size);
  assign d_last      = (d_beats == '0) ? (d_total == BEAT_W'(1)) : (d_beats == BEAT_W'(1));

  assign in0_d_valid   = out_d_valid && !d_idx;
  assign in0_d_opcode  = in0_d_valid ? out_d_opcode  : '0;
  assign in0_d_size    = in0_d_valid ? out_d_size    : '0;
  assign in0_d_source  = in0_d_valid ? out_d_source[SRC_W-1:0] : '0;
  assign in0_d_data    = in0_d_valid ? out_d_data    : '0;
  assign in0_d_denied  = in0_d_valid && out_d_denied;
  assign in0_d_corrupt = in0_d_valid && out_d_corrupt;

  assign in1_d_valid   = out_d_valid && d_idx;
  assign in1_d_opcode  = in1_d_valid ? out_d_opcode  : '0;
  assign in1_d_size    = in1_d_valid ? out_d_size    : '0;
  assign in1_d_source  = in1_d_valid ? out_d_source[SRC_W-1:0] : '0;
  assign in1_d_data    = in1_d_valid ? out_d_data    : '0;
  assign in1_d_denied  = in1_d_valid && out_d_denied;
  assign in1_d_corrupt = in1_d_valid && out_d_corrupt;

  // ---------------------------------------------------------------------------
  // Outstanding counters
  // ---------------------------------------------------------------------------
  logic inc0, inc1, dec0, dec1;

  assign inc0 = a_first && !grant;
  assign inc1 = a_first &&  grant;
  // A response with nothing outstanding is ignored for counting.
  assign dec0 = d_fire && d_last && !d_idx && (out0_cnt != '0);
  assign dec1 = d_fire && d_last &&  d_idx && (out1_cnt != '0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      a_state  <= A_IDLE;
      lock_idx <= 1'b0;
      rr_ptr   <= 1'b0;
      a_beats  <= '0;
      d_beats  <= '0;
      out0_cnt <= '0;
      out1_cnt <= '0;
    end else begin
      case (a_state)
        A_IDLE: begin
          if (a_fire) begin
            if (a_first_beats > BEAT_W'(1)) begin
              a_state  <= A_LOCKED;
              lock_idx <= grant;
              a_beats  <= a_first_beats - BEAT_W'(1);
            end else begin
              rr_ptr <= ~grant;
            end
          end else if (out_a_valid) begin
            // Stalled first beat: hold the grant so the payload stays put.
            a_state  <= A_LOCKED;
            lock_idx <= grant;
            a_beats  <= '0;
          end
        end
        A_LOCKED: begin
          if (a_fire) begin
            if (a_beats == '0) begin
              if (a_first_beats > BEAT_W'(1)) begin
                a_beats <= a_first_beats - BEAT_W'(1);
              end else begin
                a_state <= A_IDLE;
                rr_ptr  <= ~grant;
              end
            end else if (a_beats == BEAT_W'(1)) begin
              a_state <= A_IDLE;
              a_beats <= '0;
              rr_ptr  <= ~grant;
            end else begin
              a_beats <= a_beats - BEAT_W'(1);
            end
          end
        end
        default: a_state <= A_IDLE;
      endcase

      if (d_fire) begin
        if (d_last)              d_beats <= '0;
        else if (d_beats == '0)  d_beats <= d_total - BEAT_W'(1);
        else                     d_beats <= d_beats - BEAT_W'(1);
      end

      if (inc0 && !dec0)      out0_cnt <= out0_cnt + CNT_W'(1);
      else if (!inc0 && dec0) out0_cnt <= out0_cnt - CNT_W'(1);

      if (inc1 && !dec1)      out1_cnt <= out1_cnt + CNT_W'(1);
      else if (!inc1 && dec1) out1_cnt <= out1_cnt - CNT_W'(1);
    end
  end

  assign dbg_lock     = (a_state == A_LOCKED);
  assign dbg_lock_idx = lock_idx;
  assign dbg_rr_ptr   = rr_ptr;
  assign dbg_out0_cnt = out0_cnt;
  assign dbg_out1_cnt = out1_cnt;

endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
// Directed testbench for tl_ul_a_arbiter with default parameters
// (SRC_W=4, SIZE_W=3, MAX_OUT=4). Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_tl_ul_a_arbiter;

  logic        clock;
  logic        reset;

  logic        in0_a_valid, in0_a_ready;
  logic [2:0]  in0_a_opcode;
  logic [2:0]  in0_a_size;
  logic [3:0]  in0_a_source;
  logic [31:0] in0_a_address;
  logic [3:0]  in0_a_mask;
  logic [31:0] in0_a_data;

  logic        in1_a_valid, in1_a_ready;
  logic [2:0]  in1_a_opcode;
  logic [2:0]  in1_a_size;
  logic [3:0]  in1_a_source;
  logic [31:0] in1_a_address;
  logic [3:0]  in1_a_mask;
  logic [31:0] in1_a_data;

  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode;
  logic [2:0]  out_a_size;
  logic [4:0]  out_a_source;
  logic [31:0] out_a_address;
  logic [3:0]  out_a_mask;
  logic [31:0] out_a_data;

  logic        out_d_valid, out_d_ready;
  logic [2:0]  out_d_opcode;
  logic [2:0]  out_d_size;
  logic [4:0]  out_d_source;
  logic [31:0] out_d_data;
  logic        out_d_denied, out_d_corrupt;

  logic        in0_d_valid, in0_d_ready;
  logic [2:0]  in0_d_opcode;
  logic [2:0]  in0_d_size;
  logic [3:0]  in0_d_source;
  logic [31:0] in0_d_data;
  logic        in0_d_denied, in0_d_corrupt;

  logic        in1_d_valid, in1_d_ready;
  logic [2:0]  in1_d_opcode;
  logic [2:0]  in1_d_size;
  logic [3:0]  in1_d_source;
  logic [31:0] in1_d_data;
  logic        in1_d_denied, in1_d_corrupt;

  logic        dbg_lock, dbg_lock_idx, dbg_rr_ptr;
  logic [2:0]  dbg_out0_cnt, dbg_out1_cnt;

  int checks;
  int failures;

  tl_ul_a_arbiter dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_size(in0_a_size), .in0_a_source(in0_a_source), .in0_a_address(in0_a_address),
    .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_size(in1_a_size), .in1_a_source(in1_a_source), .in1_a_address(in1_a_address),
    .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address),
    .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
    .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_size(in0_d_size), .in0_d_source(in0_d_source), .in0_d_data(in0_d_data),
    .in0_d_denied(in0_d_denied), .in0_d_corrupt(in0_d_corrupt),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_size(in1_d_size), .in1_d_source(in1_d_source), .in1_d_data(in1_d_data),
    .in1_d_denied(in1_d_denied), .in1_d_corrupt(in1_d_corrupt),
    .dbg_lock(dbg_lock), .dbg_lock_idx(dbg_lock_idx), .dbg_rr_ptr(dbg_rr_ptr),
    .dbg_out0_cnt(dbg_out0_cnt), .dbg_out1_cnt(dbg_out1_cnt)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic look();
    @(negedge clock);
  endtask

  task automatic idle_all();
    in0_a_valid = 0; in0_a_opcode = 0; in0_a_size = 0; in0_a_source = 0;
    in0_a_address = 0; in0_a_mask = 0; in0_a_data = 0;
    in1_a_valid = 0; in1_a_opcode = 0; in1_a_size = 0; in1_a_source = 0;
    in1_a_address = 0; in1_a_mask = 0; in1_a_data = 0;
    out_a_ready = 0;
    out_d_valid = 0; out_d_opcode = 0; out_d_size = 0; out_d_source = 0;
    out_d_data = 0; out_d_denied = 0; out_d_corrupt = 0;
    in0_d_ready = 0; in1_d_ready = 0;
  endtask

  task automatic set_a(input int n, input logic [2:0] opcode, input logic [2:0] size,
                       input logic [3:0] source, input logic [31:0] address,
                       input logic [31:0] data);
    if (n == 0) begin
      in0_a_valid = 1; in0_a_opcode = opcode; in0_a_size = size; in0_a_source = source;
      in0_a_address = address; in0_a_mask = 4'hF; in0_a_data = data;
    end else begin
      in1_a_valid = 1; in1_a_opcode = opcode; in1_a_size = size; in1_a_source = source;
      in1_a_address = address; in1_a_mask = 4'hF; in1_a_data = data;
    end
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1;
    next();
    next();
    reset = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1;
    idle_all();

    // ---- Reset state, idle outputs ----
    do_reset();
    in0_d_ready = 1;
    look();
    chk("rst_out_a_valid", out_a_valid, 0);
    chk("rst_in0_a_ready", in0_a_ready, 0);
    chk("rst_in1_a_ready", in1_a_ready, 0);
    chk("rst_out_a_source", out_a_source, 0);
    chk("rst_in0_d_valid", in0_d_valid, 0);
    chk("rst_out_d_ready_follows_in0", out_d_ready, 1);
    chk("rst_lock", dbg_lock, 0);
    chk("rst_rr_ptr", dbg_rr_ptr, 0);
    chk("rst_cnt0", dbg_out0_cnt, 0);
    chk("rst_cnt1", dbg_out1_cnt, 0);
    next();

    // ---- Round robin: both Get size 2 every cycle ----
    do_reset();
    out_a_ready = 1;
    set_a(0, 3'd4, 3'd2, 4'h3, 32'h0000_1000, 0);
    set_a(1, 3'd4, 3'd2, 4'hA, 32'h0000_2000, 0);
    for (int i = 0; i < 4; i++) begin
      look();
      chk("rr_source", out_a_source, (i % 2 == 0) ? 5'h03 : 5'h1A);
      chk("rr_address", out_a_address, (i % 2 == 0) ? 32'h1000 : 32'h2000);
      chk("rr_in0_ready", in0_a_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_in1_ready", in1_a_ready, (i % 2 == 0) ? 0 : 1);
      next();
    end
    look();
    chk("rr_cnt0", dbg_out0_cnt, 2);
    chk("rr_cnt1", dbg_out1_cnt, 2);

    // ---- 4-beat PutFull from master 0 holds the grant ----
    do_reset();
    out_a_ready = 1;
    set_a(1, 3'd4, 3'd2, 4'h2, 32'h0000_0040, 0);
    for (int i = 0; i < 4; i++) begin
      set_a(0, 3'd0, 3'd4, 4'h1, 32'h0000_0100, 32'hD000_0000 + i);
      look();
      chk("burst_out_a_valid", out_a_valid, 1);
      chk("burst_in0_ready", in0_a_ready, 1);
      chk("burst_in1_ready", in1_a_ready, 0);
      chk("burst_data", out_a_data, 32'hD000_0000 + i);
      chk("burst_source", out_a_source, 5'h01);
      chk("burst_lock", dbg_lock, (i == 0) ? 0 : 1);
      next();
    end
    set_a(0, 3'd4, 3'd2, 4'h3, 32'h0000_0080, 0);
    look();
    chk("burst_after_in1_ready", in1_a_ready, 1);
    chk("burst_after_in0_ready", in0_a_ready, 0);
    chk("burst_after_source", out_a_source, 5'h12);
    chk("burst_after_lock", dbg_lock, 0);
    chk("burst_after_cnt0", dbg_out0_cnt, 1);
    next();

    // ---- Stall lock: master 1 held while out_a_ready=0 ----
    do_reset();
    out_a_ready = 0;
    set_a(1, 3'd4, 3'd2, 4'h5, 32'h0000_0200, 0);
    look();
    chk("stall_c1_valid", out_a_valid, 1);
    chk("stall_c1_source", out_a_source, 5'h15);
    chk("stall_c1_in1_ready", in1_a_ready, 0);
    next();
    set_a(0, 3'd4, 3'd2, 4'h6, 32'h0000_0300, 0);
    for (int i = 0; i < 2; i++) begin
      look();
      chk("stall_hold_source", out_a_source, 5'h15);
      chk("stall_hold_address", out_a_address, 32'h200);
      chk("stall_hold_in0_ready", in0_a_ready, 0);
      chk("stall_hold_lock", dbg_lock, 1);
      chk("stall_hold_lock_idx", dbg_lock_idx, 1);
      next();
    end
    out_a_ready = 1;
    look();
    chk("stall_c4_in1_ready", in1_a_ready, 1);
    chk("stall_c4_in0_ready", in0_a_ready, 0);
    next();
    in1_a_valid = 0;
    look();
    chk("stall_c5_in0_ready", in0_a_ready, 1);
    chk("stall_c5_source", out_a_source, 5'h06);
    chk("stall_c5_cnt1", dbg_out1_cnt, 1);
    next();

    // ---- Outstanding cap on master 0 ----
    do_reset();
    out_a_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_a(0, 3'd4, 3'd2, 4'(i), 32'h0000_0400, 0);
      look();
      chk("cap_fire_in0_ready", in0_a_ready, 1);
      next();
    end
    set_a(0, 3'd4, 3'd2, 4'h4, 32'h0000_0400, 0);
    set_a(1, 3'd4, 3'd2, 4'h9, 32'h0000_0500, 0);
    look();
    chk("cap_held_in0_ready", in0_a_ready, 0);
    chk("cap_in1_ready", in1_a_ready, 1);
    chk("cap_in1_source", out_a_source, 5'h19);
    chk("cap_cnt0_full", dbg_out0_cnt, 4);
    next();
    in1_a_valid = 0;
    out_d_valid = 1; out_d_opcode = 3'd1; out_d_size = 3'd2;
    out_d_source = 5'h02; out_d_data = 32'h0000_CAFE;
    in0_d_ready = 1;
    look();
    chk("cap_d_in0_ready_still_held", in0_a_ready, 0);
    chk("cap_d_out_a_valid", out_a_valid, 0);
    chk("cap_d_in0_d_valid", in0_d_valid, 1);
    chk("cap_d_in1_d_valid", in1_d_valid, 0);
    chk("cap_d_in0_d_source", in0_d_source, 4'h2);
    chk("cap_d_in0_d_data", in0_d_data, 32'hCAFE);
    chk("cap_d_out_d_ready", out_d_ready, 1);
    next();
    out_d_valid = 0;
    look();
    chk("cap_release_cnt0", dbg_out0_cnt, 3);
    chk("cap_release_in0_ready", in0_a_ready, 1);
    next();

    // ---- Get size 3 single A beat, 2-beat AccessAckData to master 1 ----
    do_reset();
    out_a_ready = 1;
    set_a(1, 3'd4, 3'd3, 4'h7, 32'h0000_0600, 0);
    look();
    chk("get8_in1_ready", in1_a_ready, 1);
    next();
    in1_a_valid = 0;
    look();
    chk("get8_no_lock", dbg_lock, 0);
    chk("get8_cnt1", dbg_out1_cnt, 1);
    out_d_valid = 1; out_d_opcode = 3'd1; out_d_size = 3'd3;
    out_d_source = 5'h17; out_d_data = 32'h1111_1111;
    in1_d_ready = 0; in0_d_ready = 1;
    next();
    look();
    chk("dbp_in1_d_valid", in1_d_valid, 1);
    chk("dbp_in0_d_valid", in0_d_valid, 0);
    chk("dbp_out_d_ready", out_d_ready, 0);
    next();
    in1_d_ready = 1;
    look();
    chk("d1_out_d_ready", out_d_ready, 1);
    chk("d1_in1_d_data", in1_d_data, 32'h1111_1111);
    chk("d1_in1_d_source", in1_d_source, 4'h7);
    next();
    out_d_data = 32'h2222_2222;
    look();
    chk("d2_cnt1_held", dbg_out1_cnt, 1);
    chk("d2_in0_d_valid", in0_d_valid, 0);
    chk("d2_in1_d_data", in1_d_data, 32'h2222_2222);
    next();
    out_d_valid = 0;
    look();
    chk("d_done_cnt1", dbg_out1_cnt, 0);
    next();

    // ---- Reset during beat 2 of a 4-beat Put ----
    do_reset();
    out_a_ready = 1;
    set_a(0, 3'd0, 3'd4, 4'h1, 32'h0000_0700, 32'hAAAA_0000);
    look();
    chk("mid_rst_beat1", in0_a_ready, 1);
    next();
    in0_a_data = 32'hAAAA_0001;
    reset = 1;
    look();
    chk("mid_rst_locked", dbg_lock, 1);
    chk("mid_rst_cnt0_before", dbg_out0_cnt, 1);
    next();
    reset = 0;
    set_a(0, 3'd4, 3'd2, 4'h3, 32'h0000_0800, 0);
    set_a(1, 3'd4, 3'd2, 4'h2, 32'h0000_0900, 0);
    look();
    chk("mid_rst_lock_cleared", dbg_lock, 0);
    chk("mid_rst_cnt0_cleared", dbg_out0_cnt, 0);
    chk("mid_rst_rr", dbg_rr_ptr, 0);
    chk("mid_rst_grant0_source", out_a_source, 5'h03);
    chk("mid_rst_grant0_ready", in0_a_ready, 1);
    next();

    idle_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
